// File: rtl/anomaly_detector.sv
// Flags raster pixels whose horizontal gradient exceeds a per-frame threshold; counts them per frame.
// Latency: one cycle, accepted pixel is presented on out_* the following cycle.
// Backpressure: single output register; in_ready = !out_valid || out_ready, outputs held while stalled.
module anomaly_detector #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  threshold,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_pixel,
    input  logic        in_sof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_pixel,
    output logic        out_flag,
    output logic        out_eol,
    output logic        out_eof,
    output logic        frame_done,
    output logic [19:0] anomaly_count,
    output logic        sof_err
);

    localparam logic [0:0]  IDLE   = 1'b0;
    localparam logic [0:0]  ACTIVE = 1'b1;
    localparam logic [11:0] X_LAST = 12'(IMG_W - 1);
    localparam logic [11:0] Y_LAST = 12'(IMG_H - 1);

    logic [0:0]  state;
    logic [11:0] x_q, y_q;
    logic [7:0]  thr_q, prev_q;
    logic [19:0] run_cnt;

    logic        acc, process, flag, eol, eof, eof_xfer;
    logic [11:0] cur_x, cur_y;
    logic [7:0]  thr_eff;
    logic [8:0]  grad;
    logic [19:0] cnt_base, cnt_nxt;

    assign in_ready = !out_valid || out_ready;

    always_comb begin
        acc      = in_valid && in_ready;
        // An SOF beat always restarts the frame, whatever state we are in.
        process  = acc && (in_sof || state == ACTIVE);
        cur_x    = in_sof ? 12'd0 : x_q;
        cur_y    = in_sof ? 12'd0 : y_q;
        thr_eff  = in_sof ? threshold : thr_q;
        grad     = 9'd0;
        if (cur_x != 12'd0) begin
            if (in_pixel >= prev_q)
                grad = {1'b0, in_pixel} - {1'b0, prev_q};
            else
                grad = {1'b0, prev_q} - {1'b0, in_pixel};
        end
        flag     = grad > {1'b0, thr_eff};
        eol      = cur_x == X_LAST;
        eof      = eol && (cur_y == Y_LAST);
        cnt_base = in_sof ? 20'd0 : run_cnt;
        cnt_nxt  = (flag && cnt_base != 20'hFFFFF) ? cnt_base + 20'd1 : cnt_base;
        eof_xfer = out_valid && out_ready && out_eof;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x_q     <= 12'd0;
            y_q     <= 12'd0;
            thr_q   <= 8'd0;
            prev_q  <= 8'd0;
            run_cnt <= 20'd0;
        end else if (process) begin
            thr_q   <= thr_eff;
            prev_q  <= in_pixel;
            run_cnt <= cnt_nxt;
            if (eol) begin
                x_q <= 12'd0;
                y_q <= eof ? 12'd0 : cur_y + 12'd1;
            end else begin
                x_q <= cur_x + 12'd1;
                y_q <= cur_y;
            end
            state <= eof ? IDLE : ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pixel <= 8'd0;
            out_flag  <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (process) begin
            out_valid <= 1'b1;
            out_pixel <= in_pixel;
            out_flag  <= flag;
            out_eol   <= eol;
            out_eof   <= eof;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // run_cnt still holds the eof beat's total here even if a new SOF clears it this same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done    <= 1'b0;
            anomaly_count <= 20'd0;
            sof_err       <= 1'b0;
        end else begin
            frame_done <= eof_xfer;
            if (eof_xfer)
                anomaly_count <= run_cnt;
            if (acc && in_sof && state == ACTIVE)
                sof_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_anomaly_detector.sv
// Bench for anomaly_detector on a 4x2 image: frame-level reference model plus literal spot checks.
module tb_anomaly_detector;

    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  threshold = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pixel = 8'd0;
    logic        in_sof = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_pixel;
    logic        out_flag, out_eol, out_eof, frame_done, sof_err;
    logic [19:0] anomaly_count;

    anomaly_detector #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .threshold(threshold),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_flag(out_flag), .out_eol(out_eol), .out_eof(out_eof),
        .frame_done(frame_done), .anomaly_count(anomaly_count), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] p;
        logic       f;
        logic       eol;
        logic       eof;
    } beat_t;
    typedef logic [7:0] frame_t [8];

    beat_t      exp_q[$];
    int         exp_cnt_q[$];
    logic [7:0] frm[$];
    bit         in_frame = 0;
    int         mthr = 0;
    int         mcnt = 0;

    int   n_chk = 0;
    int   n_fail = 0;
    int   fd_cnt = 0;
    logic obs_f[$];
    logic obs_l[$];
    logic obs_e[$];
    bit   toggle_mode = 0;
    bit   gaps = 0;

    bit         stall_prev = 0;
    bit         eof_prev = 0;
    beat_t      held;

    frame_t f1    = '{8'd10, 8'd15, 8'd40, 8'd38, 8'd0, 8'd200, 8'd190, 8'd190};
    frame_t f_alt = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255};
    frame_t f3    = '{8'd0, 8'd20, 8'd20, 8'd0, 8'd9, 8'd9, 8'd30, 8'd0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference: a frame is the list of beats since the last SOF; position gives x,y.
    function automatic void model_push(input logic [7:0] p, input logic s, input logic [7:0] thr);
        int idx, x, y;
        bit f;
        beat_t b;
        if (s) begin
            frm.delete();
            in_frame = 1;
            mthr = int'(thr);
            mcnt = 0;
        end else if (!in_frame) begin
            return;
        end
        idx = frm.size();
        x = idx % W;
        y = idx / W;
        f = (x != 0) && (absd(int'(p), int'(frm[idx-1])) > mthr);
        frm.push_back(p);
        if (f) mcnt++;
        b.p = p;
        b.f = f;
        b.eol = (x == W - 1);
        b.eof = (x == W - 1) && (y == H - 1);
        exp_q.push_back(b);
        if (b.eof) begin
            exp_cnt_q.push_back(mcnt);
            in_frame = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
            eof_prev = 0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_pixel", 32'(out_pixel), 32'(held.p));
                chk("hold_flag", 32'(out_flag), 32'(held.f));
                chk("hold_eol", 32'(out_eol), 32'(held.eol));
                chk("hold_eof", 32'(out_eof), 32'(held.eof));
            end
            chk("frame_done", 32'(frame_done), 32'(eof_prev));
            if (frame_done) begin
                fd_cnt++;
                if (exp_cnt_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame_done: got 1 expected 0");
                end else begin
                    chk("anomaly_count", 32'(anomaly_count), 32'(exp_cnt_q.pop_front()));
                end
            end
            eof_prev = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got pixel %0d expected no beat", out_pixel);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("out_pixel", 32'(out_pixel), 32'(b.p));
                    chk("out_flag", 32'(out_flag), 32'(b.f));
                    chk("out_eol", 32'(out_eol), 32'(b.eol));
                    chk("out_eof", 32'(out_eof), 32'(b.eof));
                end
                obs_f.push_back(out_flag);
                obs_l.push_back(out_eol);
                obs_e.push_back(out_eof);
                eof_prev = out_eof;
            end
            stall_prev = out_valid && !out_ready;
            held.p = out_pixel;
            held.f = out_flag;
            held.eol = out_eol;
            held.eof = out_eof;
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = toggle_mode ? ~out_ready : 1'b1;
    end

    task automatic send(input logic [7:0] p, input logic s, input logic [7:0] thr);
        bit ok = 0;
        model_push(p, s, thr);
        in_valid = 1'b1;
        in_pixel = p;
        in_sof = s;
        threshold = thr;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        in_valid = 1'b0;
        in_sof = 1'b0;
        threshold = ~thr;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input frame_t px, input logic [7:0] thr);
        for (int i = 0; i < 8; i++) send(px[i], (i == 0), thr);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || exp_cnt_q.size() != 0 || out_valid) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", 32'(k < 300), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        obs_f.delete();
        obs_l.delete();
        obs_e.delete();
        fd_cnt = 0;
    endtask

    task automatic check_f1_literals(input string tag);
        logic [7:0] vf, vl, ve;
        vf = 8'd0;
        vl = 8'd0;
        ve = 8'd0;
        chk({tag, "_beats"}, 32'(obs_f.size()), 32'd8);
        if (obs_f.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                vf[7-i] = obs_f[i];
                vl[7-i] = obs_l[i];
                ve[7-i] = obs_e[i];
            end
        end
        chk({tag, "_flags"}, 32'(vf), 32'b00100100);
        chk({tag, "_eols"}, 32'(vl), 32'b00010001);
        chk({tag, "_eofs"}, 32'(ve), 32'b00000001);
        chk({tag, "_count"}, 32'(anomaly_count), 32'd2);
        chk({tag, "_frame_done_pulses"}, 32'(fd_cnt), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pixel", 32'(out_pixel), 32'd0);
        chk("rst_out_flags", 32'({out_flag, out_eol, out_eof, frame_done}), 32'd0);
        chk("rst_count", 32'(anomaly_count), 32'd0);
        chk("rst_sof_err", 32'(sof_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame, full throughput
        clear_obs();
        send_frame(f1, 8'd10);
        drain();
        check_f1_literals("basic");

        // Same frame under 1010 backpressure and random input gaps
        clear_obs();
        toggle_mode = 1;
        gaps = 1;
        send_frame(f1, 8'd10);
        drain();
        toggle_mode = 0;
        gaps = 0;
        @(posedge clk);
        #1;
        check_f1_literals("stall");

        // Back-to-back frames: SOF accepted as the previous eof drains; threshold extremes
        clear_obs();
        send_frame(f_alt, 8'd255);
        send_frame(f_alt, 8'd0);
        drain();
        chk("thr_extremes_count", 32'(anomaly_count), 32'd6);
        chk("thr_extremes_done", 32'(fd_cnt), 32'd2);
        chk("pre_abort_sof_err", 32'(sof_err), 32'd0);

        // Abort: SOF arrives at the fourth beat of a frame
        clear_obs();
        send(8'd0, 1'b1, 8'd10);
        send(8'd100, 1'b0, 8'd10);
        send(8'd0, 1'b0, 8'd10);
        send_frame(f3, 8'd10);
        drain();
        chk("abort_sof_err", 32'(sof_err), 32'd1);
        chk("abort_done", 32'(fd_cnt), 32'd1);
        chk("abort_count", 32'(anomaly_count), 32'd4);

        // Asynchronous reset at pixel 5 with a beat held in the output register
        for (int i = 0; i < 5; i++) send(8'(i + 1), (i == 0), 8'd0);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_pixel", 32'(out_pixel), 32'd0);
        chk("arst_out_flags", 32'({out_flag, out_eol, out_eof, frame_done}), 32'd0);
        chk("arst_count", 32'(anomaly_count), 32'd0);
        chk("arst_sof_err", 32'(sof_err), 32'd0);
        exp_q.delete();
        exp_cnt_q.delete();
        in_frame = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Beats without SOF in IDLE are dropped; next SOF frame is normal
        clear_obs();
        send(8'd50, 1'b0, 8'd10);
        send(8'd60, 1'b0, 8'd10);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("idle_drop_beats", 32'(obs_f.size()), 32'd0);
        send_frame(f1, 8'd10);
        drain();
        check_f1_literals("after_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
